mdu_ctrl: RTL and testbench

- Multiply/divide unit sequencer for the 5-stage pipeline; sits in E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and runs a fixed-latency multi-cycle operation.
- Owns the HI/LO registers and serves mfhi/mflo reads.
- Drives MDU_Stall into the hazard unit so D-stage MDU instructions wait while an operation is in flight.

---
 rtl/mdu_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: fixed-latency mult/div with HI/LO ownership and D-stage stall.
// Optional madd (op 7) enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDUOp,
  input  logic [1:0]  E_MDURead,
  input  logic [31:0] E_rsData,
  input  logic [31:0] E_rtData,
  input  logic        D_MDUUse,
  output logic [31:0] E_MDUOut,
  output logic        start,
  output logic        busy,
  output logic        MDU_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [63:0] pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, lo_q;

  logic        is_mult, is_div;
  logic [31:0] divisor;
  logic signed [31:0] squo, srem;
  logic [31:0] uquo, urem;
  logic signed [63:0] sa, sb, smul;
  logic [63:0] umul;

  always_comb begin
    is_mult = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU)
`ifdef MDU_MADD_EN
              || (E_MDUOp == OP_MADD)
`endif
              ;
    is_div  = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
  end

  assign start = (state_q == S_IDLE) && !busy_q && (is_mult || is_div);

  // Substitute a divisor of 1 on zero so the divider never yields X; the result is discarded anyway.
  assign divisor = (E_rtData == 32'd0) ? 32'd1 : E_rtData;
  assign squo    = $signed(E_rsData) / $signed(divisor);
  assign srem    = $signed(E_rsData) % $signed(divisor);
  assign uquo    = E_rsData / divisor;
  assign urem    = E_rsData % divisor;

  assign sa   = {{32{E_rsData[31]}}, E_rsData};
  assign sb   = {{32{E_rtData[31]}}, E_rtData};
  assign smul = sa * sb;
  assign umul = {32'd0, E_rsData} * {32'd0, E_rtData};

  always_comb begin
    pend_d    = 64'd0;
    pend_wr_d = 1'b1;
    case (E_MDUOp)
      OP_MULT:  pend_d = smul;
      OP_MULTU: pend_d = umul;
      OP_DIV:   pend_d = {srem, squo};
      OP_DIVU:  pend_d = {urem, uquo};
`ifdef MDU_MADD_EN
      OP_MADD:  pend_d = {hi_q, lo_q} + smul;
`endif
      default:  pend_d = 64'd0;
    endcase
    if (is_div && (E_rtData == 32'd0)) pend_wr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= is_div ? DIV_N : MULT_N;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else if (E_MDUOp == OP_MTHI) begin
            hi_q <= E_rsData;
          end else if (E_MDUOp == OP_MTLO) begin
            lo_q <= E_rsData;
          end
        end
        S_RUN: begin
          // Ops seen here can only come from a flush bug and are dropped.
          if (cnt_q == 4'd1) begin
            if (pend_wr_q) {hi_q, lo_q} <= pend_q;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    E_MDUOut = 32'd0;
    case (E_MDURead)
      2'd1:    E_MDUOut = hi_q;
      2'd2:    E_MDUOut = lo_q;
      default: E_MDUOut = 32'd0;
    endcase
  end

  assign busy      = busy_q;
  assign MDU_Stall = D_MDUUse && (start || busy_q);
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected commits, a monitor checks them at busy fall.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_MDUOp;
  logic [1:0]  E_MDURead;
  logic [31:0] E_rsData, E_rtData;
  logic        D_MDUUse;
  logic [31:0] E_MDUOut, HI, LO;
  logic        start, busy, MDU_Stall;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_MDURead(E_MDURead),
    .E_rsData(E_rsData), .E_rtData(E_rtData), .D_MDUUse(D_MDUUse),
    .E_MDUOut(E_MDUOut), .start(start), .busy(busy), .MDU_Stall(MDU_Stall),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures each busy run and checks HI/LO once busy drops.
  initial begin : monitor
    bit   prev_busy;
    int   blen;
    int   slen;
    exp_t e;
    prev_busy = 1'b0;
    blen = 0;
    slen = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen++;
        if (MDU_Stall === 1'b1) slen++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("commit_hi", {32'd0, HI}, {32'd0, e.hi});
          chk("commit_lo", {32'd0, LO}, {32'd0, e.lo});
          chk("busy_len", 64'(blen), 64'(e.n));
          chk("stall_len", 64'(slen), 64'(e.n + 1));
        end
        blen = 0;
        slen = 0;
      end
      if (busy !== 1'b1 && start === 1'b1) slen = (MDU_Stall === 1'b1) ? 1 : 0;
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit exp_start, input logic [31:0] eh, input logic [31:0] el,
                       input int n);
    exp_t e;
    @(posedge clk); #1;
    E_MDUOp  = op;
    E_rsData = rs;
    E_rtData = rt;
    @(negedge clk);
    chk("start", {63'd0, start}, {63'd0, exp_start});
    if (exp_start) begin
      chk("stall_in_start", {63'd0, MDU_Stall}, 64'd1);
      e.hi = eh;
      e.lo = el;
      e.n  = n;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    E_MDUOp = 3'd0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) chk("busy_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    E_MDUOp = 3'd0;
    E_MDURead = 2'd0;
    E_rsData = 32'd0;
    E_rtData = 32'd0;
    D_MDUUse = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", {32'd0, HI}, 64'd0);
    chk("reset_lo", {32'd0, LO}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_start", {63'd0, start}, 64'd0);
    chk("reset_stall", {63'd0, MDU_Stall}, 64'd0);

    // mult -2 * 3 = -6
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_idle();

    // div -7 / 2: q=-3, r=-1
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();

    // divu 0xFFFFFFF9 / 2, with a stray mtlo injected while busy
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, 10);
    E_MDUOp  = 3'd6;
    E_rsData = 32'h0000_DEAD;
    @(negedge clk);
    chk("start_while_busy", {63'd0, start}, 64'd0);
    @(posedge clk); #1;
    E_MDUOp = 3'd0;
    wait_idle();

    // multu 0x10000 * 0x10000 = 2^32
    issue(3'd2, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000, 5);
    wait_idle();

    // Moves, then divide by zero leaves HI/LO untouched
    issue(3'd5, 32'h11, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    issue(3'd6, 32'h22, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mthi", {32'd0, HI}, 64'h11);
    chk("mtlo", {32'd0, LO}, 64'h22);
    issue(3'd3, 32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 10);
    wait_idle();
    E_MDURead = 2'd1;
    #1 chk("read_hi", {32'd0, E_MDUOut}, 64'h11);
    E_MDURead = 2'd2;
    #1 chk("read_lo", {32'd0, E_MDUOut}, 64'h22);
    E_MDURead = 2'd3;
    #1 chk("read_rsvd", {32'd0, E_MDUOut}, 64'h0);
    E_MDURead = 2'd0;

    // madd accumulates onto HI/LO = 0:FFFFFFFF
    issue(3'd5, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'd0, 0);
`ifdef MDU_MADD_EN
    issue(3'd7, 32'd1, 32'd1, 1'b1, 32'h1, 32'h0, 5);
    wait_idle();
`else
    issue(3'd7, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("op7_hi", {32'd0, HI}, 64'h0);
    chk("op7_lo", {32'd0, LO}, 64'hFFFF_FFFF);
    chk("op7_busy", {63'd0, busy}, 64'd0);
`endif

    // Reset during busy cycle 3 aborts the multu and clears HI/LO
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, 3);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (12) @(negedge clk);
    chk("abort_hi_later", {32'd0, HI}, 64'h0);
    chk("abort_lo_later", {32'd0, LO}, 64'h0);
    chk("abort_busy_later", {63'd0, busy}, 64'd0);

    @(negedge clk);
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
